// File: rtl/spmv_hbm_rd_arbiter.sv
// Round-robin AR arbiter sharing one HBM AXI read port among NUM_REQ requesters.
// R beats are steered back in issue order using a FIFO of grant IDs.
module spmv_hbm_rd_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned ADDR_W          = 48,
    parameter int unsigned LEN_W           = 4,
    parameter int unsigned MAX_OUTSTANDING = 8
) (
    input  logic                              pcie_aclk,
    input  logic                              pcie_aresetn,
    input  logic [NUM_REQ-1:0]                s_arvalid,
    output logic [NUM_REQ-1:0]                s_arready,
    input  logic [NUM_REQ*ADDR_W-1:0]         s_araddr,
    input  logic [NUM_REQ*LEN_W-1:0]          s_arlen,
    output logic [NUM_REQ-1:0]                s_rvalid,
    input  logic [NUM_REQ-1:0]                s_rready,
    output logic                              s_rlast,
    output logic [ADDR_W-1:0]                 m_axi_hbm_araddr,
    output logic [LEN_W-1:0]                  m_axi_hbm_arlen,
    output logic [2:0]                        m_axi_hbm_arsize,
    output logic [1:0]                        m_axi_hbm_arburst,
    output logic                              m_axi_hbm_arvalid,
    input  logic                              m_axi_hbm_arready,
    input  logic                              m_axi_hbm_rvalid,
    input  logic                              m_axi_hbm_rlast,
    output logic                              m_axi_hbm_rready,
    output logic [$clog2(MAX_OUTSTANDING):0]  outstanding,
    output logic                              err_unexpected_r
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_e;

    arb_state_e         state_q, state_d;
    logic               arvalid_q, arvalid_d;
    logic [ADDR_W-1:0]  araddr_q, araddr_d;
    logic [LEN_W-1:0]   arlen_q, arlen_d;
    logic [ID_W-1:0]    last_win_q, last_win_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               err_q;
    logic [ID_W-1:0]    fifo_q [MAX_OUTSTANDING];

    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [ADDR_W-1:0]  win_addr;
    logic [LEN_W-1:0]   win_len;
    logic               grant;
    logic               pop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ID_W-1:0]    head_dst;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    assign head_dst   = fifo_q[rd_ptr_q];

    // Cyclic search for the first valid requester after the last winner.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_addr  = '0;
        win_len   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!win_valid && s_arvalid[i] && (((32'(last_win_q) + k) % NUM_REQ) == i)) begin
                    win_valid = 1'b1;
                    win_id    = ID_W'(i);
                    win_addr  = s_araddr[i*ADDR_W +: ADDR_W];
                    win_len   = s_arlen[i*LEN_W +: LEN_W];
                end
            end
        end
    end

    // AR FSM: grant and latch in IDLE, hold arvalid in ISSUE until accepted.
    always_comb begin
        state_d    = state_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        last_win_d = last_win_q;
        grant      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (win_valid && !fifo_full) begin
                    grant      = 1'b1;
                    araddr_d   = win_addr;
                    arlen_d    = win_len;
                    last_win_d = win_id;
                    arvalid_d  = 1'b1;
                    state_d    = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                if (m_axi_hbm_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ARB_IDLE;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                state_d   = ARB_IDLE;
            end
        endcase
    end

    always_comb begin
        s_arready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant && (win_id == ID_W'(i))) begin
                s_arready[i] = 1'b1;
            end
        end
    end

    // R steering: only the FIFO head requester sees valid and drives ready.
    always_comb begin
        s_rvalid         = '0;
        m_axi_hbm_rready = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!fifo_empty && (head_dst == ID_W'(i))) begin
                s_rvalid[i]      = m_axi_hbm_rvalid;
                m_axi_hbm_rready = s_rready[i];
            end
        end
    end

    assign pop = m_axi_hbm_rvalid & m_axi_hbm_rready & m_axi_hbm_rlast;

    always_ff @(posedge pcie_aclk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            state_q    <= ARB_IDLE;
            arvalid_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            last_win_q <= ID_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            last_win_q <= last_win_d;
        end
    end

    always_ff @(posedge pcie_aclk or negedge pcie_aresetn) begin
        if (!pcie_aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            if (grant) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({grant, pop})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (m_axi_hbm_rvalid && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // Order-FIFO storage needs no reset; pointers and count define validity.
    always_ff @(posedge pcie_aclk) begin
        if (grant) begin
            fifo_q[wr_ptr_q] <= win_id;
        end
    end

    assign m_axi_hbm_araddr  = araddr_q;
    assign m_axi_hbm_arlen   = arlen_q;
    assign m_axi_hbm_arsize  = 3'b101;
    assign m_axi_hbm_arburst = 2'b01;
    assign m_axi_hbm_arvalid = arvalid_q;
    assign s_rlast           = m_axi_hbm_rlast;
    assign outstanding       = cnt_q;
    assign err_unexpected_r  = err_q;

endmodule

// File: tb/tb_spmv_hbm_rd_arbiter.sv
// Scoreboard bench for spmv_hbm_rd_arbiter: expected AR bursts and R routing are queued
// when requests are driven and compared as the HBM side issues and returns them.
module tb_spmv_hbm_rd_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 48;
    localparam int unsigned LEN_W   = 4;
    localparam int unsigned MAX_OUT = 8;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic [NUM_REQ-1:0]          s_arvalid = '0;
    logic [NUM_REQ-1:0]          s_arready;
    logic [NUM_REQ*ADDR_W-1:0]   s_araddr;
    logic [NUM_REQ*LEN_W-1:0]    s_arlen;
    logic [NUM_REQ-1:0]          s_rvalid;
    logic [NUM_REQ-1:0]          s_rready = '1;
    logic                        s_rlast;
    logic [ADDR_W-1:0]           m_araddr;
    logic [LEN_W-1:0]            m_arlen;
    logic [2:0]                  m_arsize;
    logic [1:0]                  m_arburst;
    logic                        m_arvalid;
    logic                        m_arready = 1'b0;
    logic                        m_rvalid = 1'b0;
    logic                        m_rlast = 1'b0;
    logic                        m_rready;
    logic [$clog2(MAX_OUT):0]    outstanding;
    logic                        err_unexpected_r;

    logic [ADDR_W-1:0]           req_addr [NUM_REQ];
    logic [LEN_W-1:0]            req_len  [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
        assign s_araddr[g*ADDR_W +: ADDR_W] = req_addr[g];
        assign s_arlen[g*LEN_W +: LEN_W]    = req_len[g];
    end

    always #5 clk = ~clk;

    spmv_hbm_rd_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .pcie_aclk(clk),
        .pcie_aresetn(rst_n),
        .s_arvalid(s_arvalid),
        .s_arready(s_arready),
        .s_araddr(s_araddr),
        .s_arlen(s_arlen),
        .s_rvalid(s_rvalid),
        .s_rready(s_rready),
        .s_rlast(s_rlast),
        .m_axi_hbm_araddr(m_araddr),
        .m_axi_hbm_arlen(m_arlen),
        .m_axi_hbm_arsize(m_arsize),
        .m_axi_hbm_arburst(m_arburst),
        .m_axi_hbm_arvalid(m_arvalid),
        .m_axi_hbm_arready(m_arready),
        .m_axi_hbm_rvalid(m_rvalid),
        .m_axi_hbm_rlast(m_rlast),
        .m_axi_hbm_rready(m_rready),
        .outstanding(outstanding),
        .err_unexpected_r(err_unexpected_r)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        int unsigned       id;
    } burst_t;

    burst_t      ar_q[$];
    burst_t      r_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Raise one requester's arvalid until granted; queue the expected AR burst.
    task automatic request(input int unsigned id, input logic [ADDR_W-1:0] addr,
                           input logic [LEN_W-1:0] len);
        bit done = 1'b0;
        req_addr[id] = addr;
        req_len[id]  = len;
        s_arvalid[id] = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            settle();
            if (s_arready != '0) begin
                check_eq("ar_grant", 64'(s_arready), 64'(1) << id);
                ar_q.push_back('{addr, len, id});
                done = 1'b1;
            end
            step();
        end
        if (done) begin
            settle();
            check_eq("ar_pulse", 64'(s_arready), 64'(0));
        end else begin
            check_eq("ar_grant_timeout", 64'(0), 64'(1));
        end
        s_arvalid[id] = 1'b0;
    endtask

    // Accept one AR on the HBM side and compare against the scoreboard.
    task automatic accept_ar();
        bit     done = 1'b0;
        burst_t b;
        m_arready = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            settle();
            if (m_arvalid) begin
                if (ar_q.size() == 0) begin
                    check_eq("ar_unexpected", 64'(1), 64'(0));
                end else begin
                    b = ar_q.pop_front();
                    check_eq("araddr", 64'(m_araddr), 64'(b.addr));
                    check_eq("arlen", 64'(m_arlen), 64'(b.len));
                    r_q.push_back(b);
                end
                done = 1'b1;
            end
            step();
        end
        m_arready = 1'b0;
        if (!done) check_eq("ar_issue_timeout", 64'(0), 64'(1));
    endtask

    // Return the oldest issued burst beat by beat and check its routing.
    task automatic return_burst();
        burst_t b;
        if (r_q.size() == 0) begin
            check_eq("r_queue_empty", 64'(1), 64'(0));
            return;
        end
        b = r_q.pop_front();
        for (int unsigned beat = 0; beat <= 32'(b.len); beat++) begin
            m_rvalid = 1'b1;
            m_rlast  = (beat == 32'(b.len));
            settle();
            check_eq("s_rvalid", 64'(s_rvalid), 64'(1) << b.id);
            check_eq("m_rready", 64'(m_rready), 64'(1));
            check_eq("s_rlast", 64'(s_rlast), 64'(beat == 32'(b.len)));
            step();
        end
        m_rvalid = 1'b0;
        m_rlast  = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned n_g;
        int unsigned n_i;
        int unsigned exp_id;
        burst_t      b;

        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_addr[i] = '0;
            req_len[i]  = '0;
        end
        step();
        step();
        settle();
        check_eq("rst_arvalid", 64'(m_arvalid), 64'(0));
        check_eq("rst_araddr", 64'(m_araddr), 64'(0));
        check_eq("rst_arlen", 64'(m_arlen), 64'(0));
        check_eq("rst_outstanding", 64'(outstanding), 64'(0));
        check_eq("rst_err", 64'(err_unexpected_r), 64'(0));
        check_eq("rst_rready", 64'(m_rready), 64'(0));
        check_eq("arsize", 64'(m_arsize), 64'(5));
        check_eq("arburst", 64'(m_arburst), 64'(1));
        rst_n = 1'b1;
        step();

        // Single burst from requester 0
        request(0, 48'h1000, 4'd3);
        accept_ar();
        check_eq("t1_outstanding", 64'(outstanding), 64'(1));
        return_burst();
        settle();
        check_eq("t1_outstanding_done", 64'(outstanding), 64'(0));
        step();

        // Both requesters held high: grants alternate from requester 0
        pulse_reset();
        req_addr[0] = 48'h0;    req_len[0] = 4'd1;
        req_addr[1] = 48'h8000; req_len[1] = 4'd2;
        s_arvalid = 2'b11;
        m_arready = 1'b1;
        n_g = 0;
        n_i = 0;
        for (int c = 0; c < 30 && (n_g < 4 || n_i < 4); c++) begin
            settle();
            if (s_arready != '0) begin
                exp_id = n_g % 2;
                check_eq("rr_grant", 64'(s_arready), 64'(1) << exp_id);
                ar_q.push_back('{req_addr[exp_id], req_len[exp_id], exp_id});
                n_g++;
            end
            if (m_arvalid) begin
                if (ar_q.size() == 0) begin
                    check_eq("rr_ar_unexpected", 64'(1), 64'(0));
                end else begin
                    b = ar_q.pop_front();
                    check_eq("rr_araddr", 64'(m_araddr), 64'(b.addr));
                    check_eq("rr_arlen", 64'(m_arlen), 64'(b.len));
                    r_q.push_back(b);
                end
                n_i++;
            end
            step();
            if (n_g == 4) s_arvalid = '0;
        end
        s_arvalid = '0;
        m_arready = 1'b0;
        check_eq("rr_grant_count", 64'(n_g), 64'(4));
        check_eq("rr_issue_count", 64'(n_i), 64'(4));
        settle();
        check_eq("rr_outstanding", 64'(outstanding), 64'(4));
        for (int k = 0; k < 4; k++) return_burst();

        // Fill the order FIFO from requester 0; the ninth waits for a pop
        for (int unsigned k = 0; k < MAX_OUT; k++) begin
            request(0, 48'h10000 + 48'(k * 32), 4'd0);
            accept_ar();
        end
        settle();
        check_eq("full_outstanding", 64'(outstanding), 64'(MAX_OUT));
        step();
        req_addr[0] = 48'hABC00;
        req_len[0]  = 4'd0;
        s_arvalid[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_eq("full_no_grant", 64'(s_arready), 64'(0));
            step();
        end
        return_burst();
        settle();
        check_eq("ninth_grant", 64'(s_arready), 64'(1));
        if (s_arready[0]) ar_q.push_back('{48'hABC00, 4'd0, 0});
        step();
        s_arvalid[0] = 1'b0;
        accept_ar();
        settle();
        check_eq("refill_outstanding", 64'(outstanding), 64'(MAX_OUT));
        for (int k = 0; k < 20 && r_q.size() > 0; k++) return_burst();
        settle();
        check_eq("drain_outstanding", 64'(outstanding), 64'(0));
        step();

        // Head burst owned by requester 1 which is not ready
        request(1, 48'h2000, 4'd1);
        accept_ar();
        request(0, 48'h3000, 4'd0);
        accept_ar();
        s_rready = 2'b01;
        m_rvalid = 1'b1;
        m_rlast  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check_eq("blocked_rready", 64'(m_rready), 64'(0));
            check_eq("blocked_rvalid", 64'(s_rvalid), 64'(2));
            check_eq("blocked_outstanding", 64'(outstanding), 64'(2));
            step();
        end
        m_rvalid = 1'b0;
        s_rready = 2'b11;
        return_burst();
        return_burst();

        // R beat while nothing is outstanding
        settle();
        check_eq("err_clear", 64'(err_unexpected_r), 64'(0));
        step();
        m_rvalid = 1'b1;
        settle();
        check_eq("unexp_rready", 64'(m_rready), 64'(0));
        check_eq("unexp_rvalid", 64'(s_rvalid), 64'(0));
        step();
        m_rvalid = 1'b0;
        settle();
        check_eq("err_set", 64'(err_unexpected_r), 64'(1));
        step();
        step();
        settle();
        check_eq("err_sticky", 64'(err_unexpected_r), 64'(1));
        step();

        // Reset while ARB_ISSUE with three outstanding
        request(0, 48'h4000, 4'd0);
        accept_ar();
        request(1, 48'h5000, 4'd0);
        accept_ar();
        request(0, 48'h6000, 4'd0);
        settle();
        check_eq("pre_rst_arvalid", 64'(m_arvalid), 64'(1));
        check_eq("pre_rst_outstanding", 64'(outstanding), 64'(3));
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_arvalid", 64'(m_arvalid), 64'(0));
        check_eq("mid_rst_outstanding", 64'(outstanding), 64'(0));
        check_eq("mid_rst_err", 64'(err_unexpected_r), 64'(0));
        ar_q.delete();
        r_q.delete();
        step();
        step();
        rst_n = 1'b1;
        step();
        req_addr[0] = 48'h7000;
        req_addr[1] = 48'h9000;
        s_arvalid = 2'b11;
        settle();
        check_eq("post_rst_grant", 64'(s_arready), 64'(1));
        step();
        s_arvalid = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
